// File: rtl/c_prefix_net_pipe.sv
// c_prefix_net_pipe: pipelined Kogge-Stone generate/propagate prefix network.
// The log2(width) prefix levels are split over elastic register stages with a
// valid/ready handshake on each side; optional cyclic (wraparound) combining.
// Element 0 is the lowest-order element. The vector is padded at the low end
// with identity elements (g=0, p=1) up to a power of two; padding never shows.
module c_prefix_net_pipe #(
  parameter int WIDTH = 16,
  parameter bit ENABLE_WRAPAROUND = 1'b0,
  parameter int LEVELS_PER_STAGE = 1,
  localparam int DEPTH = $clog2(WIDTH),
  localparam int EXT_WIDTH = 1 << DEPTH,
  localparam int NUM_STAGES = (DEPTH + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE,
  localparam int OCC_WIDTH = $clog2(NUM_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:WIDTH-1]     g_in,
  input  logic [0:WIDTH-1]     p_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:WIDTH-1]     g_out,
  output logic [0:WIDTH-1]     p_out,
  output logic [OCC_WIDTH-1:0] occupancy
);

  localparam int PAD = EXT_WIDTH - WIDTH;

  // Illegal parameter combinations stop elaboration.
  if (WIDTH < 2) begin : g_err_width
    $error("c_prefix_net_pipe: WIDTH must be >= 2");
  end
  if (ENABLE_WRAPAROUND && (EXT_WIDTH != WIDTH)) begin : g_err_wrap
    $error("c_prefix_net_pipe: wraparound needs a power-of-two WIDTH");
  end
  if ((LEVELS_PER_STAGE < 1) || (LEVELS_PER_STAGE > DEPTH)) begin : g_err_lps
    $error("c_prefix_net_pipe: LEVELS_PER_STAGE must be in 1..DEPTH");
  end

  // Applies prefix levels lo..hi-1 to a (g, p) vector; returns {p, g}.
  // Elements whose partner index falls below 0 pass through unchanged in the
  // linear case (equivalent to combining with an identity element). In the
  // cyclic case the partner index wraps modulo EXT_WIDTH, which is exactly
  // what truncating the signed offset to DEPTH bits gives.
  function automatic logic [2*EXT_WIDTH-1:0] prefix_levels(
    input logic [EXT_WIDTH-1:0] g_i,
    input logic [EXT_WIDTH-1:0] p_i,
    input int                   lo,
    input int                   hi
  );
    logic [EXT_WIDTH-1:0] g_c, p_c, g_n, p_n;
    int src;
    g_c = g_i;
    p_c = p_i;
    for (int l = 0; l < DEPTH; l++) begin
      if (l >= lo && l < hi) begin
        g_n = g_c;
        p_n = p_c;
        for (int i = 0; i < EXT_WIDTH; i++) begin
          src = i - (1 << l);
          if (src >= 0 || ENABLE_WRAPAROUND) begin
            g_n[i] = g_c[i] | (p_c[i] & g_c[DEPTH'(src)]);
            p_n[i] = p_c[i] & p_c[DEPTH'(src)];
          end
        end
        g_c = g_n;
        p_c = p_n;
      end
    end
    return {p_c, g_c};
  endfunction

  // Padded input vectors, element k at bit k.
  logic [EXT_WIDTH-1:0] ext_g, ext_p;

  for (genvar gi = 0; gi < EXT_WIDTH; gi++) begin : g_pad
    if (gi < PAD) begin : g_ident
      assign ext_g[gi] = 1'b0;
      assign ext_p[gi] = 1'b1;
    end else begin : g_data
      assign ext_g[gi] = g_in[gi-PAD];
      assign ext_p[gi] = p_in[gi-PAD];
    end
  end

  logic [EXT_WIDTH-1:0]  stage_g_q [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  stage_p_q [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  stage_g_d [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  stage_p_d [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  src_g     [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  src_p     [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  lvl_g     [NUM_STAGES];
  logic [EXT_WIDTH-1:0]  lvl_p     [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] up_valid;
  logic [NUM_STAGES-1:0] stage_ready;

  // Per-stage combinational slice of the network; the last stage may carry
  // fewer levels than LEVELS_PER_STAGE.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    localparam int LO = gi * LEVELS_PER_STAGE;
    localparam int HI = (LO + LEVELS_PER_STAGE > DEPTH) ? DEPTH : LO + LEVELS_PER_STAGE;
    if (gi == 0) begin : g_first
      assign src_g[gi]    = ext_g;
      assign src_p[gi]    = ext_p;
      assign up_valid[gi] = in_valid;
    end else begin : g_next
      assign src_g[gi]    = stage_g_q[gi-1];
      assign src_p[gi]    = stage_p_q[gi-1];
      assign up_valid[gi] = valid_q[gi-1];
    end
    assign {lvl_p[gi], lvl_g[gi]} = prefix_levels(src_g[gi], src_p[gi], LO, HI);
  end

  // Ready chain from the consumer back to the input: a stage can take a beat
  // when it is empty or everything downstream of it can move.
  always_comb begin
    logic r;
    r = out_ready;
    stage_ready = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      r = ~valid_q[s] | r;
      stage_ready[s] = r;
    end
  end

  // Next stage state: load when ready, hold when stalled, flush drops validity.
  always_comb begin
    valid_d = valid_q;
    for (int s = 0; s < NUM_STAGES; s++) begin
      stage_g_d[s] = stage_g_q[s];
      stage_p_d[s] = stage_p_q[s];
      if (flush) begin
        valid_d[s] = 1'b0;
      end else if (stage_ready[s]) begin
        valid_d[s] = up_valid[s];
      end
      if (stage_ready[s] && up_valid[s]) begin
        stage_g_d[s] = lvl_g[s];
        stage_p_d[s] = lvl_p[s];
      end
    end
  end

  // Stage registers with asynchronous clear of data and valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stage_g_q[s] <= '0;
        stage_p_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stage_g_q[s] <= stage_g_d[s];
        stage_p_q[s] <= stage_p_d[s];
      end
    end
  end

  // Occupancy is the population count of the current stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      occupancy = occupancy + OCC_WIDTH'(valid_q[s]);
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[NUM_STAGES-1];

  // Strip the low-end padding from the final stage.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_map
    assign g_out[gi] = stage_g_q[NUM_STAGES-1][PAD+gi];
    assign p_out[gi] = stage_p_q[NUM_STAGES-1][PAD+gi];
  end

endmodule

// File: tb/tb_c_prefix_net_pipe.sv
// tb_c_prefix_net_pipe: directed checks of c_prefix_net_pipe in three
// configurations (width 8 linear, width 8 cyclic, width 13 two-level stages).
module tb_c_prefix_net_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, flush;

  // A: width 8, linear, 1 level per stage (3 stages)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [0:7] a_g_in, a_p_in, a_g_out, a_p_out;
  logic [1:0] a_occ;
  // B: width 8, cyclic, 2 levels per stage (2 stages)
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:7] b_g_in, b_p_in, b_g_out, b_p_out;
  logic [1:0] b_occ;
  // C: width 13, linear, 2 levels per stage (2 stages, padded to 16)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [0:12] c_g_in, c_p_in, c_g_out, c_p_out;
  logic [1:0]  c_occ;

  c_prefix_net_pipe #(.WIDTH(8), .ENABLE_WRAPAROUND(1'b0), .LEVELS_PER_STAGE(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .g_in(a_g_in), .p_in(a_p_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .g_out(a_g_out), .p_out(a_p_out),
    .occupancy(a_occ));

  c_prefix_net_pipe #(.WIDTH(8), .ENABLE_WRAPAROUND(1'b1), .LEVELS_PER_STAGE(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .g_in(b_g_in), .p_in(b_p_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .g_out(b_g_out), .p_out(b_p_out),
    .occupancy(b_occ));

  c_prefix_net_pipe #(.WIDTH(13), .ENABLE_WRAPAROUND(1'b0), .LEVELS_PER_STAGE(2)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .g_in(c_g_in), .p_in(c_p_in),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .g_out(c_g_out), .p_out(c_p_out),
    .occupancy(c_occ));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-computed vectors, written in index order 0..7 left to right.
  logic [0:7] vg [5], vp [5], eg [5], ep [5];
  logic [0:7] wg [4], wp [4], xg [4], xp [4];

  // Direct evaluation of the linear prefix definition for width 13.
  function automatic logic [25:0] ref13(input logic [0:12] g, input logic [0:12] p);
    logic [0:12] go, po;
    logic t;
    for (int i = 0; i < 13; i++) begin
      go[i] = 1'b0;
      po[i] = 1'b1;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        go[i] = go[i] | t;
        po[i] = po[i] & p[j];
      end
    end
    return {go, po};
  endfunction

  task automatic run_a(input int k);
    int lat;
    @(negedge clk);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_g_in = vg[k]; a_p_in = vp[k];
    #1 check($sformatf("a_rdy%0d", k), a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("a_lat%0d", k), lat, 3);
    check($sformatf("a_g%0d", k), a_g_out, eg[k]);
    check($sformatf("a_p%0d", k), a_p_out, ep[k]);
    $display("A beat %0d: g_in=%b p_in=%b -> g_out=%b p_out=%b lat=%0d",
             k, vg[k], vp[k], a_g_out, a_p_out, lat);
  endtask

  task automatic run_b(input int k);
    int lat;
    @(negedge clk);
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_g_in = wg[k]; b_p_in = wp[k];
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("b_lat%0d", k), lat, 2);
    check($sformatf("b_g%0d", k), b_g_out, xg[k]);
    check($sformatf("b_p%0d", k), b_p_out, xp[k]);
    $display("B beat %0d: g_in=%b p_in=%b -> g_out=%b p_out=%b lat=%0d",
             k, wg[k], wp[k], b_g_out, b_p_out, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, rcv, gaps, thru;
    bit started;
    logic [25:0] r;
    logic [0:12] q_g [$];
    logic [0:12] q_p [$];
    logic [0:12] eg13, ep13;

    vg = '{8'b00100000, 8'b00100000, 8'b10000001, 8'b00000000, 8'b01000100};
    vp = '{8'b11111111, 8'b11110111, 8'b01111110, 8'b11111111, 8'b10110111};
    eg = '{8'b00111111, 8'b00110000, 8'b11111111, 8'b00000000, 8'b01110111};
    ep = '{8'b11111111, 8'b11110000, 8'b00000000, 8'b11111111, 8'b10000000};
    wg = '{8'b00000100, 8'b00000100, 8'b00000000, 8'b10000000};
    wp = '{8'b11111111, 8'b01111111, 8'b11111111, 8'b10111111};
    xg = '{8'b11111111, 8'b00000111, 8'b00000000, 8'b10000000};
    xp = '{8'b11111111, 8'b00000000, 8'b11111111, 8'b00000000};

    reset_n = 1'b0; flush = 1'b0;
    a_in_valid = 0; a_out_ready = 1; a_g_in = '0; a_p_in = '0;
    b_in_valid = 0; b_out_ready = 1; b_g_in = '0; b_p_in = '0;
    c_in_valid = 0; c_out_ready = 1; c_g_in = '0; c_p_in = '0;

    // Reset state
    #3;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_occ", a_occ, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_g_out", a_g_out, 0);
    check("rst_p_out", a_p_out, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single beats, linear and cyclic
    for (int k = 0; k < 5; k++) run_a(k);
    for (int k = 0; k < 4; k++) run_b(k);

    // Backpressure: five beats offered into a stalled 3-stage pipe
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_g_in = vg[sent]; a_p_in = vp[sent];
      #1;
      if (a_in_ready) sent++;
    end
    check("bp_sent", sent, 3);
    check("bp_in_ready", a_in_ready, 0);
    check("bp_occ", a_occ, 3);
    check("bp_out_valid", a_out_valid, 1);
    check("bp_hold_g", a_g_out, eg[0]);
    check("bp_hold_p", a_p_out, ep[0]);
    rcv = 0; gaps = 0; started = 0;
    for (int c = 0; c < 20 && rcv < 5; c++) begin
      @(negedge clk);
      a_out_ready = 1'b1;
      a_in_valid = (sent < 5);
      if (sent < 5) begin
        a_g_in = vg[sent];
        a_p_in = vp[sent];
      end
      #1;
      if (a_out_valid) begin
        check($sformatf("bp_g%0d", rcv), a_g_out, eg[rcv]);
        check($sformatf("bp_p%0d", rcv), a_p_out, ep[rcv]);
        $display("A drain %0d: g_out=%b p_out=%b", rcv, a_g_out, a_p_out);
        rcv++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      if (a_in_valid && a_in_ready) sent++;
    end
    a_in_valid = 1'b0;
    check("bp_rcv", rcv, 5);
    check("bp_gaps", gaps, 0);

    // Flush with three beats in flight; the beat offered with flush is dropped
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_g_in = vg[c]; a_p_in = vp[c];
    end
    @(negedge clk);
    check("fl_occ_before", a_occ, 3);
    flush = 1'b1; a_in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; a_in_valid = 1'b0;
    check("fl_occ", a_occ, 0);
    check("fl_out_valid", a_out_valid, 0);
    @(negedge clk);
    check("fl_occ_drop", a_occ, 0);
    $display("A flush: occupancy=%0d out_valid=%0d", a_occ, a_out_valid);

    // Asynchronous reset mid-stream
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_g_in = vg[0]; a_p_in = vp[0];
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    check("ar_occ_before", a_occ, 3);
    #2 reset_n = 1'b0;
    #1;
    check("ar_occ", a_occ, 0);
    check("ar_out_valid", a_out_valid, 0);
    check("ar_g_out", a_g_out, 0);
    check("ar_p_out", a_p_out, 0);
    $display("A async reset: occupancy=%0d out_valid=%0d", a_occ, a_out_valid);
    @(negedge clk);
    reset_n = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("ar_no_ghost", a_out_valid, 0);

    // Width 13: full-rate window, then random valid/ready, then drain
    thru = 0;
    for (int cyc = 0; cyc < 230; cyc++) begin
      @(negedge clk);
      if (cyc < 12) begin
        c_in_valid = 1'b1; c_out_ready = 1'b1;
      end else if (cyc < 200) begin
        c_in_valid = 1'($urandom_range(0, 1));
        c_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        c_in_valid = 1'b0; c_out_ready = 1'b1;
      end
      c_g_in = 13'($urandom) & 13'($urandom);
      c_p_in = 13'($urandom) | 13'($urandom);
      #1;
      if (c_in_valid && c_in_ready) begin
        r = ref13(c_g_in, c_p_in);
        q_g.push_back(r[25:13]);
        q_p.push_back(r[12:0]);
      end
      if (c_out_valid && c_out_ready) begin
        if (cyc >= 2 && cyc < 12) thru++;
        if (q_g.size() == 0) begin
          check("c_extra_beat", 1, 0);
        end else begin
          eg13 = q_g.pop_front();
          ep13 = q_p.pop_front();
          check("c_g", c_g_out, eg13);
          check("c_p", c_p_out, ep13);
        end
      end
    end
    check("c_thru", thru, 10);
    check("c_left", q_g.size(), 0);
    check("c_occ_end", c_occ, 0);
    $display("C random: %0d full-rate results, %0d left", thru, q_g.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
